// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings and FSM state type for the multiply/divide unit
package muldiv_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_MULT  = 3'b001;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b011;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b101;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b110;
    typedef enum logic [1:0] {IDLE, RUN, FIX} muldiv_state_t;
endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: one-bit-per-step shift-add multiply / restoring divide datapath
module muldiv_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [WIDTH-1:0] acc, q, m;
    logic [WIDTH:0]   x, y, sum;

    // Shared step adder: add multiplicand (mul) or subtract divisor from shifted remainder (div)
    always_comb begin
        x   = mode ? {acc, q[WIDTH-1]} : {1'b0, acc};
        y   = mode ? ~{1'b0, m} : (q[0] ? {1'b0, m} : '0);
        sum = x + y + {{WIDTH{1'b0}}, mode};
    end

    // Accumulator/remainder in acc, multiplier/quotient in q; remainder never exceeds WIDTH bits once restored
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
            m   <= '0;
        end else if (load) begin
            acc <= '0;
            q   <= load_a;
            m   <= load_b;
        end else if (step) begin
            acc <= mode ? (sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
            q   <= mode ? {q[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], q[WIDTH-1:1]};
        end
    end

    assign res_hi = acc;
    assign res_lo = q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply-divide with architectural HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t      state;
    logic [CW-1:0]      cnt;
    logic               sa, sb, div_r, dz;
    logic               is_md, sgn, is_dv, load, step;
    logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // Decode the request and form operand magnitudes and sign-corrected results
    always_comb begin
        is_md    = op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
        sgn      = op == OP_MULT || op == OP_DIV;
        is_dv    = op == OP_DIV || op == OP_DIVU;
        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        load     = state == IDLE && start && !flush && is_md;
        step     = state == RUN && !flush;
        prod_fix = (sa ^ sb) ? -{res_hi, res_lo} : {res_hi, res_lo};
        q_fix    = (sa ^ sb) ? -res_lo : res_lo;
        r_fix    = sa ? -res_hi : res_hi;
    end

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .mode   (div_r),
        .load_a (mag_a),
        .load_b (mag_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Control FSM, iteration counter, sign flags and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            div_r <= 1'b0;
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                if (load) begin
                    sa    <= sgn & a[WIDTH-1];
                    sb    <= sgn & b[WIDTH-1];
                    div_r <= is_dv;
                    dz    <= is_dv && b == '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= (is_dv && b == '0) ? FIX : RUN;
                end else if (start && op == OP_MTHI) begin
                    hi <= a;
                end else if (start && op == OP_MTLO) begin
                    lo <= a;
                end
            end else if (state == RUN) begin
                cnt   <= cnt + 1'b1;
                state <= (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
            end else begin
                if (!dz) begin
                    hi <= div_r ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo <= div_r ? q_fix : prod_fix[WIDTH-1:0];
                end
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector and sequence checks for muldiv_unit at WIDTH=32
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk, rst, start, flush, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
    } vec_t;

    vec_t v[11];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        next();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            next();
            lat++;
        end
    endtask

    initial begin
        int lat, seen;
        v[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 34};
        v[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        v[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        v[3]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        34};
        v[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34};
        v[5]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
        v[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34};
        v[7]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        34};
        v[8]  = '{OP_DIVU,  32'd99,       32'd0,        32'd1,        32'd0,        2};
        v[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        34};
        v[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        34};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            accept(v[i].op, v[i].a, v[i].b);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_hi", i), hi, v[i].eh);
            chk($sformatf("v%0d_lo", i), lo, v[i].el);
            chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
            next();
        end

        accept(OP_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_done", {31'd0, done}, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        accept(OP_MTLO, 32'h5678, 32'd0);
        chk("mtlo_lo", lo, 32'h5678);

        accept(OP_DIV, 32'd100, 32'd7);
        repeat (9) next();
        flush = 1'b1;
        next();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen = 1;
            next();
        end
        chk("flush_no_done", seen, 0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h5678);

        flush = 1'b1;
        accept(OP_MTHI, 32'hBEEF, 32'd0);
        flush = 1'b0;
        chk("flush_drops_mthi", hi, 32'h1234);

        accept(OP_MULTU, 32'd3, 32'd5);
        repeat (4) next();
        accept(OP_MTHI, 32'hDEAD, 32'd0);
        wait_done(lat);
        chk("busy_start_lat", lat + 5, 34);
        chk("busy_start_hi", hi, 32'd0);
        chk("busy_start_lo", lo, 32'd15);

        accept(OP_MULTU, 32'd2, 32'd3);
        wait_done(lat);
        chk("b2b_first_lo", lo, 32'd6);
        accept(OP_MULTU, 32'd4, 32'd5);
        wait_done(lat);
        chk("b2b_lat", lat, 34);
        chk("b2b_second_lo", lo, 32'd20);

        accept(OP_MULT, 32'd9, 32'd9);
        repeat (5) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen = 1;
            next();
        end
        chk("rst_run_no_done", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
